// File: rtl/fma_result_collector_pkg.sv
// Shared types and defaults for the FMA array return path.
package fma_result_collector_pkg;

    localparam int unsigned FMA_BW_FP      = 17;
    localparam int unsigned FMA_NLANE      = 128;
    localparam int unsigned FMA_VALUE_MN   = 64;
    localparam int unsigned FMA_BEAT_LANES = 32;

    typedef enum logic [1:0] {
        CL_NONE  = 2'd0,
        CL_ROPE  = 2'd1,
        CL_NORM1 = 2'd2,
        CL_POST  = 2'd3
    } client_e;

    // Number of SRAM write beats needed to drain one entry of the given client.
    function automatic int unsigned beats_for(input client_e cl,
                                              input int unsigned nlane,
                                              input int unsigned value_mn,
                                              input int unsigned beat_lanes);
        return (cl == CL_POST) ? (value_mn / beat_lanes) : (nlane / beat_lanes);
    endfunction

endpackage

// File: rtl/fma_result_collector_if.sv
// SRAM write-beat bus: collector is master, SRAM side is slave.
interface fma_result_collector_if
    import fma_result_collector_pkg::*;
#(
    parameter int unsigned BW_FP      = FMA_BW_FP,
    parameter int unsigned NLANE      = FMA_NLANE,
    parameter int unsigned BEAT_LANES = FMA_BEAT_LANES
) ();

    localparam int unsigned BEAT_W = $clog2(NLANE / BEAT_LANES);

    logic                          wr_valid;
    logic                          wr_ready;
    logic [BEAT_LANES*BW_FP-1:0]   wr_data;
    logic [1:0]                    wr_client;
    logic [BEAT_W-1:0]             wr_beat;
    logic                          wr_last;

    modport master (
        output wr_valid, wr_data, wr_client, wr_beat, wr_last,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_data, wr_client, wr_beat, wr_last,
        output wr_ready
    );

endinterface

// File: rtl/fma_result_collector_fifo.sv
// Synchronous result buffer; pointers carry an extra wrap bit to tell full from empty.
module fma_result_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // Push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr[AW-1:0]];

    // Pointer update; clear overrides push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clear) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    // Entry storage, written on accepted push.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wptr[AW-1:0]] <= wdata;
    end

    // Credit accounting upstream must make an unpaired push to a full buffer impossible.
    assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop && !clear));

endmodule

// File: rtl/fma_result_collector.sv
// Return path of the shared FMA array: tags each issue with its client, captures
// the array output after FMA_LAT cycles, buffers it and streams it as write beats.
module fma_result_collector
    import fma_result_collector_pkg::*;
#(
    parameter int unsigned BW_FP      = FMA_BW_FP,
    parameter int unsigned NLANE      = FMA_NLANE,
    parameter int unsigned VALUE_MN   = FMA_VALUE_MN,
    parameter int unsigned FMA_LAT    = 4,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned BEAT_LANES = FMA_BEAT_LANES
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      issue_valid,
    input  logic [1:0]                issue_client,
    output logic                      issue_ready,
    input  logic [NLANE*BW_FP-1:0]    fma_out,
    fma_result_collector_if.master    wr,
    output logic [$clog2(DEPTH):0]    occupancy,
    output logic                      busy,
    output logic                      ovf_err
);

    localparam int unsigned ENTRY_W = NLANE * BW_FP;
    localparam int unsigned SLICE_W = BEAT_LANES * BW_FP;
    localparam int unsigned BEAT_W  = $clog2(NLANE / BEAT_LANES);
    localparam int unsigned OCC_W   = $clog2(DEPTH) + 1;

    client_e              issue_cl;
    logic                 accept;
    logic                 reject;
    logic                 tag_vld [FMA_LAT];
    client_e              tag_cl  [FMA_LAT];
    logic [ENTRY_W-1:0]   cap_data;
    logic                 push;
    logic                 pop;
    logic [ENTRY_W+1:0]   head;
    logic                 fifo_empty;
    client_e              head_cl;
    logic [BEAT_W-1:0]    beat;
    logic                 last_beat;
    logic [OCC_W-1:0]     occ;

    assign issue_cl    = client_e'(issue_client);
    // Credits cover both in-flight and buffered entries, so the array can never overrun the buffer.
    assign issue_ready = (occ < OCC_W'(DEPTH));
    assign accept      = issue_valid && issue_ready && (issue_cl != CL_NONE);
    assign reject      = issue_valid && !issue_ready && (issue_cl != CL_NONE);

    assign push      = tag_vld[FMA_LAT-1] && !flush;
    assign head_cl   = client_e'(head[ENTRY_W +: 2]);
    assign last_beat = (beat == BEAT_W'(beats_for(head_cl, NLANE, VALUE_MN, BEAT_LANES) - 1));
    assign pop       = wr.wr_valid && wr.wr_ready && last_beat && !flush;

    assign wr.wr_valid  = !fifo_empty;
    assign wr.wr_data   = wr.wr_valid ? head[32'(beat) * SLICE_W +: SLICE_W] : '0;
    assign wr.wr_client = wr.wr_valid ? head[ENTRY_W +: 2] : 2'b00;
    assign wr.wr_beat   = beat;
    assign wr.wr_last   = wr.wr_valid && last_beat;

    assign occupancy = occ;
    assign busy      = (occ != '0);

    // Tag pipe: one {valid, client} stage per array pipeline cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FMA_LAT; i++) begin
                tag_vld[i] <= 1'b0;
                tag_cl[i]  <= CL_NONE;
            end
        end else if (flush) begin
            for (int unsigned i = 0; i < FMA_LAT; i++) begin
                tag_vld[i] <= 1'b0;
                tag_cl[i]  <= CL_NONE;
            end
        end else begin
            tag_vld[0] <= accept;
            tag_cl[0]  <= issue_cl;
            for (int unsigned i = 1; i < FMA_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_cl[i]  <= tag_cl[i-1];
            end
        end
    end

    // Post-attention-norm results only carry the low VALUE_MN lanes; zero the rest.
    always_comb begin
        cap_data = fma_out;
        if (tag_cl[FMA_LAT-1] == CL_POST) begin
            for (int unsigned i = VALUE_MN; i < NLANE; i++) begin
                cap_data[i*BW_FP +: BW_FP] = '0;
            end
        end
    end

    fma_result_fifo #(
        .WIDTH (ENTRY_W + 2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .wdata ({tag_cl[FMA_LAT-1], cap_data}),
        .rdata (head),
        .empty (fifo_empty)
    );

    // Beat index within the head entry; wraps to 0 when the entry is popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat <= '0;
        end else if (flush) begin
            beat <= '0;
        end else if (wr.wr_valid && wr.wr_ready) begin
            beat <= last_beat ? '0 : beat + 1'b1;
        end
    end

    // Credit counter: +1 on accept, -1 on last-beat handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ <= '0;
        end else if (flush) begin
            occ <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Sticky overflow flag for issues attempted without credit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_err <= 1'b0;
        end else if (flush) begin
            ovf_err <= 1'b0;
        end else if (reject) begin
            ovf_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fma_result_collector.sv
// Directed bench for fma_result_collector: table of single issues plus
// hand-written back-pressure, overflow, push/pop and flush sequences.
module tb_fma_result_collector;
    import fma_result_collector_pkg::*;

    localparam int unsigned BW  = 17;
    localparam int unsigned NL  = 128;
    localparam int unsigned VM  = 64;
    localparam int unsigned LAT = 4;
    localparam int unsigned DEP = 4;
    localparam int unsigned BL  = 32;
    localparam int unsigned SW  = BL * BW;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  flush = 1'b0;
    logic                  issue_valid = 1'b0;
    logic [1:0]            issue_client = 2'd0;
    logic                  issue_ready;
    logic [NL*BW-1:0]      fma_out;
    logic [$clog2(DEP):0]  occupancy;
    logic                  busy;
    logic                  ovf_err;
    logic [9:0]            cur_seed = '0;
    logic                  cur_hi = 1'b0;

    int unsigned checks = 0;
    int unsigned errors = 0;

    fma_result_collector_if #(.BW_FP(BW), .NLANE(NL), .BEAT_LANES(BL)) wr_bus ();

    fma_result_collector #(
        .BW_FP(BW), .NLANE(NL), .VALUE_MN(VM), .FMA_LAT(LAT), .DEPTH(DEP), .BEAT_LANES(BL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .issue_valid(issue_valid), .issue_client(issue_client), .issue_ready(issue_ready),
        .fma_out(fma_out), .wr(wr_bus),
        .occupancy(occupancy), .busy(busy), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    // Stand-in for the FMA array: whatever was loaded comes out LAT cycles later.
    logic [11:0] stage [LAT];
    always @(posedge clk) begin
        stage[0] <= {issue_valid, cur_seed, cur_hi};
        for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
    end

    function automatic logic [16:0] lane_val(input logic [9:0] seed, input logic hi, input int unsigned lane);
        if (hi && lane >= 64) return 17'h1FFFF;
        return {seed, lane[6:0]};
    endfunction

    always_comb begin
        fma_out = '0;
        for (int unsigned i = 0; i < NL; i++) begin
            fma_out[i*BW +: BW] = stage[LAT-1][11] ? lane_val(stage[LAT-1][10:1], stage[LAT-1][0], i) : 17'h1FFFF;
        end
    end

    function automatic logic [SW-1:0] exp_slice(input logic [1:0] cl, input logic [9:0] seed,
                                               input logic hi, input int unsigned bt);
        logic [SW-1:0] s;
        s = '0;
        for (int unsigned j = 0; j < BL; j++) begin
            int unsigned lane;
            lane = bt * BL + j;
            if (cl == 2'd3 && lane >= VM) s[j*BW +: BW] = '0;
            else                          s[j*BW +: BW] = lane_val(seed, hi, lane);
        end
        return s;
    endfunction

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_data(input string nm, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard of accepted issues, in issue order.
    typedef struct { logic [1:0] cl; logic [9:0] seed; logic hi; } exp_t;
    exp_t        exp_q[$];
    exp_t        mon_e;
    int unsigned mon_beat = 0;
    int unsigned mon_nb;
    int unsigned beats_seen = 0;

    always @(negedge clk) begin
        if (rst_n && wr_bus.wr_valid && wr_bus.wr_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got client %0d beat %0d, expected no beat",
                         wr_bus.wr_client, wr_bus.wr_beat);
            end else begin
                mon_e  = exp_q[0];
                mon_nb = (mon_e.cl == 2'd3) ? 2 : 4;
                chk("beat_client", wr_bus.wr_client, mon_e.cl);
                chk("beat_index", wr_bus.wr_beat, mon_beat);
                chk("beat_last", wr_bus.wr_last, (mon_beat == mon_nb - 1));
                chk_data("beat_data", wr_bus.wr_data, exp_slice(mon_e.cl, mon_e.seed, mon_e.hi, mon_beat));
                beats_seen++;
                if (mon_beat == mon_nb - 1) begin
                    void'(exp_q.pop_front());
                    mon_beat = 0;
                end else begin
                    mon_beat++;
                end
            end
        end
    end

    task automatic issue(input logic [1:0] cl, input logic [9:0] seed, input logic hi, input logic exp_ready);
        @(posedge clk);
        #1;
        issue_valid  = 1'b1;
        issue_client = cl;
        cur_seed     = seed;
        cur_hi       = hi;
        #1;
        chk("issue_ready", issue_ready, exp_ready);
        if (exp_ready && cl != 2'd0) exp_q.push_back('{cl: cl, seed: seed, hi: hi});
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        issue_valid  = 1'b0;
        issue_client = 2'd0;
    endtask

    task automatic wait_drain(input string nm, input int unsigned limit);
        int unsigned n;
        n = 0;
        while ((busy || wr_bus.wr_valid) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(nm, (n < limit), 1);
    endtask

    typedef struct { logic [1:0] cl; logic [9:0] seed; logic hi; int unsigned beats; int unsigned lat; } vec_t;
    vec_t vecs [5];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1);
    end

    initial begin
        int unsigned lat;
        int unsigned found;
        int unsigned n;
        int unsigned seen;
        bit          done;

        vecs[0] = '{cl: 2'd1, seed: 10'd1, hi: 1'b0, beats: 4, lat: LAT + 1};
        vecs[1] = '{cl: 2'd2, seed: 10'd2, hi: 1'b1, beats: 4, lat: LAT + 1};
        vecs[2] = '{cl: 2'd3, seed: 10'd3, hi: 1'b1, beats: 2, lat: LAT + 1};
        vecs[3] = '{cl: 2'd3, seed: 10'd4, hi: 1'b0, beats: 2, lat: LAT + 1};
        vecs[4] = '{cl: 2'd0, seed: 10'd5, hi: 1'b0, beats: 0, lat: 0};

        wr_bus.wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_issue_ready", issue_ready, 1);
        chk("rst_wr_valid", wr_bus.wr_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf_err", ovf_err, 0);
        chk("rst_wr_last", wr_bus.wr_last, 0);
        chk("rst_wr_beat", wr_bus.wr_beat, 0);
        chk("rst_wr_client", wr_bus.wr_client, 0);
        chk_data("rst_wr_data", wr_bus.wr_data, '0);

        // Single issues with the write side always ready.
        for (int k = 0; k < 5; k++) begin
            beats_seen = 0;
            issue(vecs[k].cl, vecs[k].seed, vecs[k].hi, 1'b1);
            idle();
            lat   = 0;
            found = 0;
            for (int unsigned c = 1; c <= 12 && found == 0; c++) begin
                @(negedge clk);
                if (wr_bus.wr_valid) begin
                    found = 1;
                    lat   = c;
                end
            end
            if (vecs[k].beats != 0) chk("first_valid_latency", lat, vecs[k].lat);
            else                    chk("client0_no_output", found, 0);
            wait_drain("single_drain", 50);
            chk("beat_count", beats_seen, vecs[k].beats);
            chk("single_occupancy", occupancy, 0);
            chk("single_ovf_err", ovf_err, 0);
        end

        // Fill all credits with the write side stalled, then overflow.
        @(posedge clk);
        #1 wr_bus.wr_ready = 1'b0;
        issue(2'd1, 10'd10, 1'b0, 1'b1);
        issue(2'd2, 10'd11, 1'b0, 1'b1);
        issue(2'd3, 10'd12, 1'b1, 1'b1);
        issue(2'd1, 10'd13, 1'b0, 1'b1);
        issue(2'd2, 10'd14, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        chk("full_occupancy", occupancy, 4);
        chk("full_issue_ready", issue_ready, 0);
        chk("full_ovf_err", ovf_err, 1);
        chk("full_busy", busy, 1);

        // Two beats out, then a long stall mid-entry.
        n = 0;
        while (!wr_bus.wr_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("stall_valid_seen", (n < 20), 1);
        @(posedge clk);
        #1 wr_bus.wr_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 wr_bus.wr_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("stall_valid", wr_bus.wr_valid, 1);
            chk("stall_beat", wr_bus.wr_beat, 2);
            chk("stall_client", wr_bus.wr_client, 1);
            chk("stall_last", wr_bus.wr_last, 0);
            chk_data("stall_data", wr_bus.wr_data, exp_slice(2'd1, 10'd10, 1'b0, 2));
        end

        // Toggle ready; issue in the cycle a last beat pops while one credit is free.
        done = 0;
        n    = 0;
        while (!done && n < 200) begin
            @(posedge clk);
            #1 wr_bus.wr_ready = (n % 2 == 0);
            #1;
            if (occupancy == 3 && wr_bus.wr_valid && wr_bus.wr_ready && wr_bus.wr_last) begin
                issue_valid  = 1'b1;
                issue_client = 2'd3;
                cur_seed     = 10'd20;
                cur_hi       = 1'b0;
                chk("pushpop_issue_ready", issue_ready, 1);
                exp_q.push_back('{cl: 2'd3, seed: 10'd20, hi: 1'b0});
                done = 1;
            end
            n++;
        end
        chk("pushpop_found", done, 1);
        idle();
        wr_bus.wr_ready = 1'b0;
        @(negedge clk);
        chk("pushpop_occupancy", occupancy, 3);
        issue(2'd2, 10'd21, 1'b0, 1'b1);
        idle();
        @(negedge clk);
        chk("refill_occupancy", occupancy, 4);
        chk("refill_issue_ready", issue_ready, 0);
        n = 0;
        while ((busy || wr_bus.wr_valid) && n < 300) begin
            @(posedge clk);
            #1 wr_bus.wr_ready = ~wr_bus.wr_ready;
            n++;
        end
        chk("toggle_drain", (n < 300), 1);
        chk("order_all_delivered", exp_q.size(), 0);

        // Flush with two entries buffered and two in flight.
        @(posedge clk);
        #1 wr_bus.wr_ready = 1'b0;
        issue(2'd1, 10'd30, 1'b0, 1'b1);
        issue(2'd2, 10'd31, 1'b0, 1'b1);
        idle();
        repeat (3) @(posedge clk);
        issue(2'd3, 10'd32, 1'b0, 1'b1);
        issue(2'd1, 10'd33, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        issue_client = 2'd0;
        chk("preflush_occupancy", occupancy, 4);
        chk("preflush_ovf_err", ovf_err, 1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        exp_q.delete();
        mon_beat = 0;
        @(negedge clk);
        chk("flush_wr_valid", wr_bus.wr_valid, 0);
        chk("flush_occupancy", occupancy, 0);
        chk("flush_ovf_err", ovf_err, 0);
        chk("flush_issue_ready", issue_ready, 1);
        chk("flush_busy", busy, 0);
        @(posedge clk);
        #1 wr_bus.wr_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (wr_bus.wr_valid) seen++;
        end
        chk("flush_inflight_ignored", seen, 0);

        // Normal operation after flush.
        beats_seen = 0;
        issue(2'd1, 10'd40, 1'b0, 1'b1);
        idle();
        wait_drain("postflush_drain", 50);
        chk("postflush_beats", beats_seen, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
